// File: rtl/ir_tx_scheduler_pkg.sv
// ir_tx_scheduler_pkg: scheduler FSM states, NEC frame period and round-robin pointer helper
package ir_tx_scheduler_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
  localparam int NEC_FRAME_TICKS = 10800;
  localparam int REP_SAT = 255;
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/ir_tx_scheduler_rr_arbiter.sv
// ir_rr_arbiter: combinational winner pick, round-robin from i_ptr or lowest index under IR_SCHED_FIXED_PRIO_EN
module ir_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  always_comb begin
    o_idx = '0;
    // scan from farthest to nearest so the nearest requester overwrites last
    for (int k = N - 1; k >= 0; k--) begin
`ifdef IR_SCHED_FIXED_PRIO_EN
      if (i_req[k]) o_idx = IW'(k);
`else
      if (i_req[(int'(i_ptr) + k) % N]) o_idx = IW'((int'(i_ptr) + k) % N);
`endif
    end
  end
  assign o_valid = |i_req;
  assign o_onehot = o_valid ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: shares one NEC encoder between N requesters, full frame then 108 ms repeats while held
// IR_SCHED_FIXED_PRIO_EN: lowest index wins and the owner repeats without a fairness bound
module ir_tx_scheduler import ir_tx_scheduler_pkg::*; #(
  parameter int N           = 4,
  parameter int CODEBITS    = 32,
  parameter int FRAME_TICKS = NEC_FRAME_TICKS,
  parameter int MAX_REPEAT  = 8,
  localparam int IW = $clog2(N),
  localparam int PW = $clog2(FRAME_TICKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          hold,
  input  logic [N*CODEBITS-1:0] code_in,
  output logic [N-1:0]          grant,
  output logic                  enc_start,
  output logic                  enc_repeat,
  output logic [CODEBITS-1:0]   enc_code,
  input  logic                  enc_done,
  output logic                  busy,
  output logic [IW-1:0]         owner
);
  state_t                r_state;
  logic [IW-1:0]         r_owner;
  logic [IW-1:0]         r_ptr;
  logic [CODEBITS-1:0]   r_code;
  logic [N-1:0]          r_grant;
  logic                  r_start;
  logic                  r_repeat;
  logic [PW-1:0]         r_period;
  logic [7:0]            r_rep;
  logic [N-1:0]          w_onehot;
  logic [IW-1:0]         w_idx;
  logic                  w_valid;
  logic                  w_at_end;
  logic                  w_expire;
  logic                  w_again;
  logic [PW-1:0]         w_period_nxt;
  ir_rr_arbiter #(.N(N)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_onehot(w_onehot),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );
  assign w_at_end = r_period == PW'(FRAME_TICKS - 1);
  assign w_expire = tick && w_at_end;
  assign w_period_nxt = (tick && !w_at_end) ? r_period + PW'(1) : r_period;
`ifdef IR_SCHED_FIXED_PRIO_EN
  assign w_again = hold[r_owner];
`else
  assign w_again = hold[r_owner] &&
                   (!(|(req & ~(N'(1) << r_owner))) || r_rep < 8'(MAX_REPEAT));
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_code   <= '0;
      r_grant  <= '0;
      r_start  <= 1'b0;
      r_repeat <= 1'b0;
      r_period <= '0;
      r_rep    <= '0;
    end else begin
      r_grant  <= '0;
      r_start  <= 1'b0;
      r_repeat <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_valid) begin
          r_state  <= ST_SEND;
          r_owner  <= w_idx;
          r_code   <= code_in[int'(w_idx)*CODEBITS +: CODEBITS];
          r_grant  <= w_onehot;
          r_start  <= 1'b1;
          r_period <= '0;
          r_rep    <= '0;
`ifndef IR_SCHED_FIXED_PRIO_EN
          r_ptr    <= IW'(rr_next(int'(w_idx), N));
`endif
        end
        // an expiry coinciding with enc_done is deferred to the next tick in GAP
        ST_SEND: begin
          r_period <= w_period_nxt;
          if (enc_done) r_state <= ST_GAP;
        end
        ST_GAP: if (w_expire) begin
          if (w_again) begin
            r_state  <= ST_SEND;
            r_start  <= 1'b1;
            r_repeat <= 1'b1;
            r_period <= '0;
            r_rep    <= (r_rep == 8'(REP_SAT)) ? r_rep : r_rep + 8'd1;
          end else begin
            r_state  <= ST_IDLE;
          end
        end else begin
          r_period <= w_period_nxt;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign grant      = r_grant;
  assign enc_start  = r_start;
  assign enc_repeat = r_repeat;
  assign enc_code   = r_code;
  assign busy       = r_state != ST_IDLE;
  assign owner      = r_owner;
endmodule

// File: tb/tb_ir_tx_scheduler.sv
// tb_ir_tx_scheduler: randomized ticks/encoder latency, frame-level reference model of grants and repeats
module tb_ir_tx_scheduler;
  localparam int N = 4, CB = 32, FT = 12, MR = 8;
  logic clk = 0, rst = 1;
  logic tick;
  logic [N-1:0] req = '0, hold = '0;
  logic [N*CB-1:0] code_in = '0;
  logic [N-1:0] grant;
  logic enc_start, enc_repeat, enc_done, busy;
  logic [CB-1:0] enc_code;
  logic [1:0] owner;
  logic auto_tick = 1, tick_r = 0, man_tick = 0;
  logic auto_enc = 1, auto_done = 0, man_done = 0;
  int done_cnt = 0, tick_total = 0, checks = 0, errors = 0, ptr = 0;
  typedef struct {int t; logic rep; logic [N-1:0] g; logic [1:0] own; logic [CB-1:0] code;} ev_t;
  ev_t evq[$];

  assign tick = auto_tick ? tick_r : man_tick;
  assign enc_done = auto_done | man_done;
  always #5 clk = ~clk;

  ir_tx_scheduler #(.N(N), .CODEBITS(CB), .FRAME_TICKS(FT), .MAX_REPEAT(MR)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .hold(hold), .code_in(code_in),
    .grant(grant), .enc_start(enc_start), .enc_repeat(enc_repeat), .enc_code(enc_code),
    .enc_done(enc_done), .busy(busy), .owner(owner));

  always @(posedge clk) if (tick) tick_total++;

  // random tick pattern, encoder model finishing each frame 2..6 clocks after launch, frame log
  always @(negedge clk) begin
    tick_r = 1'($urandom_range(0, 1));
    auto_done = 0;
    if (done_cnt == 1) auto_done = auto_enc;
    if (done_cnt > 0) done_cnt--;
    if (enc_start && auto_enc) done_cnt = $urandom_range(2, 6);
    if (enc_start) evq.push_back('{tick_total, enc_repeat, grant, owner, enc_code});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic new_codes;
    for (int i = 0; i < N; i++) code_in[i*CB +: CB] = $urandom;
  endtask

  task automatic wait_grant(input string nm, output logic [N-1:0] g);
    int n = 0;
    do begin @(negedge clk); n++; end while (grant == 0 && n < 2000);
    g = grant;
    if (grant == 0) begin
      checks++; errors++;
      $display("FAIL %s: no grant within %0d clocks, got grant=%b", nm, n, grant);
    end
  endtask

  task automatic wait_idle(input string nm, output int t);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    t = tick_total;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s: busy=%b after timeout, required 0", nm, busy); end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, enc_start, enc_repeat, busy, owner} !== '0) begin
      errors++; $display("FAIL reset_ctrl: grant=%b start=%b rep=%b busy=%b owner=%0d, required all 0",
                         grant, enc_start, enc_repeat, busy, owner);
    end
    checks++;
    if (enc_code !== '0) begin errors++; $display("FAIL reset_code: got %h, required 0", enc_code); end
    rst = 0; ptr = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release: busy=%b, required 0", busy); end
  endtask

  task automatic test_single;
    int t_idle;
    new_codes(); evq.delete();
    req = 4'b0001; hold = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || enc_start !== 1'b1 || enc_repeat !== 1'b0) begin
      errors++; $display("FAIL single_launch: grant=%b start=%b rep=%b, required 0001/1/0", grant, enc_start, enc_repeat);
    end
    checks++;
    if (enc_code !== code_in[CB-1:0]) begin errors++; $display("FAIL single_code: got %h, required %h", enc_code, code_in[CB-1:0]); end
    checks++;
    if (busy !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL single_busy: busy=%b owner=%0d, required 1/0", busy, owner); end
    req = '0; ptr = 1;
    wait_idle("single_idle", t_idle);
    @(negedge clk);
    checks++;
    if (evq.size() != 1) begin errors++; $display("FAIL single_frames: got %0d frames, required 1", evq.size()); end
    else begin
      checks++;
      if (t_idle - evq[0].t != FT) begin errors++; $display("FAIL single_period: idle after %0d ticks, required %0d", t_idle - evq[0].t, FT); end
    end
  endtask

  task automatic test_hold(input int o, input int r);
    int n = 0, cyc = 0, t_idle;
    logic [N-1:0] g;
    logic [CB-1:0] c;
    new_codes(); evq.delete();
    c = code_in[o*CB +: CB];
    req[o] = 1; hold[o] = 1;
    wait_grant("hold_grant", g);
    req[o] = 0; ptr = (o + 1) % N;
    code_in[o*CB +: CB] = ~c;
    while (n < r && cyc < 5000) begin @(negedge clk); cyc++; if (enc_start) n++; end
    hold[o] = 0;
    wait_idle("hold_idle", t_idle);
    @(negedge clk);
    checks++;
    if (evq.size() != r + 1) begin errors++; $display("FAIL hold_frames: got %0d frames, required %0d", evq.size(), r + 1); end
    else begin
      for (int i = 0; i <= r; i++) begin
        checks++;
        if (evq[i].rep !== (i > 0) || evq[i].own !== 2'(o) || evq[i].code !== c ||
            evq[i].g !== ((i == 0) ? 4'(1 << o) : 4'b0)) begin
          errors++; $display("FAIL hold_frame%0d: rep=%b own=%0d code=%h grant=%b, required rep=%b own=%0d code=%h",
                             i, evq[i].rep, evq[i].own, evq[i].code, evq[i].g, i > 0, o, c);
        end
        if (i > 0) begin
          checks++;
          if (evq[i].t - evq[i-1].t != FT) begin errors++; $display("FAIL hold_spacing%0d: got %0d ticks, required %0d", i, evq[i].t - evq[i-1].t, FT); end
        end
      end
      checks++;
      if (t_idle - evq[r].t != FT) begin errors++; $display("FAIL hold_tail: idle after %0d ticks, required %0d", t_idle - evq[r].t, FT); end
    end
  endtask

  task automatic test_rr(input logic [N-1:0] m);
    logic [N-1:0] g, exp_g;
    int w, t;
    hold = '0; req = m;
    for (int k = 0; k < N && req != 0; k++) begin
      w = rr_pick(req, ptr);
      exp_g = '0; exp_g[w] = 1'b1;
      wait_grant("rr_grant", g);
      checks++;
      if (g !== exp_g) begin errors++; $display("FAIL rr_order: pending=%b ptr=%0d got grant=%b, required %b", req, ptr, g, exp_g); end
      req = req & ~exp_g; ptr = (w + 1) % N;
    end
    req = '0;
    wait_idle("rr_idle", t);
  endtask

  task automatic test_fair(input int o, input int p);
    logic [N-1:0] g;
    int t, n_o = 0, last_o = 0;
    new_codes(); evq.delete();
    req[o] = 1; hold[o] = 1;
    wait_grant("fair_owner", g);
    req[o] = 0; req[p] = 1; ptr = (o + 1) % N;
    wait_grant("fair_other", g);
    checks++;
    if (g !== 4'(1 << p)) begin errors++; $display("FAIL fair_grant: got %b, required %b", g, 4'(1 << p)); end
    req[p] = 0; hold[o] = 0; ptr = (p + 1) % N;
    wait_idle("fair_idle", t);
    @(negedge clk);
    foreach (evq[i]) if (evq[i].own == 2'(o) && evq[i].g != 4'(1 << p)) begin n_o++; last_o = evq[i].t; end
    checks++;
    if (n_o != MR + 1) begin errors++; $display("FAIL fair_repeats: owner sent %0d frames, required %0d", n_o, MR + 1); end
    checks++;
    if (evq.size() == 0 || evq[evq.size()-1].rep !== 1'b0 || evq[evq.size()-1].own !== 2'(p) ||
        evq[evq.size()-1].t - last_o < FT || evq[evq.size()-1].t - last_o > FT + 1) begin
      errors++; $display("FAIL fair_handover: %0d frames logged, last frame not a full frame of %0d at %0d..%0d ticks", evq.size(), p, FT, FT + 1);
    end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] g;
    req[2] = 1; hold[2] = 1;
    wait_grant("rmid_grant", g);
    req = '0;
    @(negedge clk);
    rst = 1; #1;
    checks++;
    if ({grant, enc_start, enc_repeat, busy, owner} !== '0 || enc_code !== '0) begin
      errors++; $display("FAIL rmid_async: grant=%b start=%b busy=%b owner=%0d code=%h, required all 0", grant, enc_start, busy, owner, enc_code);
    end
    @(negedge clk);
    hold = '0; rst = 0; ptr = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_state: busy=%b, required 0", busy); end
    test_rr(4'b1010);
  endtask

  task automatic test_coincide(input int o);
    logic [N-1:0] g;
    int t;
    auto_tick = 0; auto_enc = 0; man_tick = 0;
    req[o] = 1; hold[o] = 1;
    wait_grant("coin_grant", g);
    req[o] = 0; ptr = (o + 1) % N;
    for (int k = 0; k < FT - 1; k++) begin man_tick = 1; @(negedge clk); end
    man_tick = 1; man_done = 1; @(negedge clk);
    man_tick = 0; man_done = 0;
    checks++;
    if (enc_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL coin_early: start=%b busy=%b, required 0/1", enc_start, busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (enc_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL coin_wait: start=%b busy=%b, required 0/1", enc_start, busy); end
    man_tick = 1; @(negedge clk); man_tick = 0;
    checks++;
    if (enc_start !== 1'b1 || enc_repeat !== 1'b1 || owner !== 2'(o)) begin
      errors++; $display("FAIL coin_repeat: start=%b rep=%b owner=%0d, required 1/1/%0d", enc_start, enc_repeat, owner, o);
    end
    hold[o] = 0; man_done = 1; @(negedge clk); man_done = 0;
    for (int k = 0; k < FT - 1; k++) begin man_tick = 1; @(negedge clk); end
    man_tick = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL coin_hold_off: busy=%b one tick before expiry, required 1", busy); end
    man_tick = 1; @(negedge clk); man_tick = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL coin_idle: busy=%b at expiry, required 0", busy); end
    auto_tick = 1; auto_enc = 1;
    wait_idle("coin_final", t);
  endtask

  initial begin
    int o, p;
    logic [N-1:0] m;
    new_codes();
    test_reset();
    test_single();
    test_hold(2, 3);
    test_rr(4'b1111);
    test_rr(4'b0001);
    for (int k = 0; k < 4; k++) begin
      m = 4'($urandom_range(1, 15));
      test_rr(m);
      test_hold($urandom_range(0, N - 1), $urandom_range(1, 3));
    end
    test_hold($urandom_range(0, N - 1), MR + 2);
    test_fair(1, 3);
    o = $urandom_range(0, N - 1);
    p = (o + $urandom_range(1, N - 1)) % N;
    test_fair(o, p);
    test_reset_mid();
    test_coincide($urandom_range(0, N - 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
